y_fetch_pc: RTL and testbench

- Instruction-fetch front end built around the next-PC select path: a PC register whose input is the 2:1 choice between sequential (PC+4) and redirect target.
- Issues word fetches to instruction memory over a req/ack handshake.
- Buffers one fetched instruction and presents it to the decode stage over a valid/ready handshake.
- Sits directly upstream of decode; its redirect input comes from the branch/jump resolution logic.

---
 rtl/y_fetch_pc.sv | 137 +++++++++++++
 tb/tb_y_fetch_pc.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/y_fetch_pc.sv
// Instruction-fetch front end: PC register with sequential/redirect next-PC select,
// req/ack fetch from instruction memory and a one-entry buffer towards decode.
module y_fetch_pc #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          DATA_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [DATA_W-1:0]   imem_rdata,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [DATA_W-1:0]   inst,
    output logic [ADDR_W-1:0]   inst_pc
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt;
    logic [ADDR_W-1:0]   pend_pc, pend_pc_nxt;
    logic                flush, flush_nxt;
    logic [DATA_W-1:0]   inst_nxt;
    logic [ADDR_W-1:0]   inst_pc_nxt;

    logic [ADDR_W-1:0]   redirect_tgt;
    logic [ADDR_W-1:0]   pc_seq;
    logic [ADDR_W-1:0]   pc_target;
    logic                pc_load;
    logic                pc_take_target;

    assign redirect_tgt = redirect_pc & ALIGN_MASK;
    assign pc_seq       = pc + PC_STEP;

    // Next-PC select: target on redirect or flush commit, otherwise PC+4
    always_comb begin
        pc_nxt = pc;
        if (pc_load) begin
            pc_nxt = pc_take_target ? pc_target : pc_seq;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt      = state;
        flush_nxt      = flush;
        pend_pc_nxt    = pend_pc;
        inst_nxt       = inst;
        inst_pc_nxt    = inst_pc;
        pc_load        = 1'b0;
        pc_take_target = 1'b0;
        pc_target      = redirect_tgt;

        case (state)
            IDLE: begin
                state_nxt = FETCH;
                if (redirect_valid) begin
                    pc_load        = 1'b1;
                    pc_take_target = 1'b1;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        pc_load        = 1'b1;
                        pc_take_target = 1'b1;
                        flush_nxt      = 1'b0;
                    end else if (flush) begin
                        pc_load        = 1'b1;
                        pc_take_target = 1'b1;
                        pc_target      = pend_pc;
                        flush_nxt      = 1'b0;
                    end else begin
                        inst_nxt    = imem_rdata;
                        inst_pc_nxt = pc;
                        state_nxt   = OUT;
                    end
                end else if (redirect_valid) begin
                    // address must stay stable until ack, so park the target
                    pend_pc_nxt = redirect_tgt;
                    flush_nxt   = 1'b1;
                end
            end
            OUT: begin
                if (redirect_valid) begin
                    pc_load        = 1'b1;
                    pc_take_target = 1'b1;
                    state_nxt      = FETCH;
                end else if (inst_ready) begin
                    pc_load   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            flush      <= 1'b0;
            pend_pc    <= '0;
            inst       <= '0;
            inst_pc    <= '0;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            flush      <= flush_nxt;
            pend_pc    <= pend_pc_nxt;
            inst       <= inst_nxt;
            inst_pc    <= inst_pc_nxt;
            imem_req   <= (state_nxt == FETCH);
            inst_valid <= (state_nxt == OUT);
        end
    end

    assign imem_addr = pc;

endmodule

// File: tb/tb_y_fetch_pc.sv
// Directed and randomized checks of y_fetch_pc against a transaction-level fetch model.
module tb_y_fetch_pc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int errors = 0;
    int checks = 0;

    // Model: what the front end is doing from the outside point of view
    logic        m_req;       // fetch outstanding
    logic        m_valid;     // instruction offered to decode
    logic [31:0] m_addr;      // address being / to be fetched
    logic [31:0] m_inst;
    logic [31:0] m_inst_pc;
    logic        m_stale;     // current fetch's data is to be dropped
    logic [31:0] m_stale_to;  // where fetching resumes after the drop

    y_fetch_pc dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req      = 1'b0;
        m_valid    = 1'b0;
        m_addr     = 32'h0;
        m_inst     = 32'h0;
        m_inst_pc  = 32'h0;
        m_stale    = 1'b0;
        m_stale_to = 32'h0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".req"},     32'(imem_req),   32'(m_req));
        check({tag, ".addr"},    imem_addr,       m_addr);
        check({tag, ".valid"},   32'(inst_valid), 32'(m_valid));
        check({tag, ".inst"},    inst,            m_inst);
        check({tag, ".inst_pc"}, inst_pc,         m_inst_pc);
    endtask

    function automatic logic [31:0] pat();
        return m_addr ^ 32'hA5A5_0000;
    endfunction

    // One clock: drive inputs, advance the model by the fetch rules, compare after the edge
    task automatic step(input string tag, input logic rv, input logic [31:0] rpc,
                        input logic ack, input logic rdy, input logic [31:0] rd);
        logic [31:0] tgt;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ack       = ack;
        inst_ready     = rdy;
        imem_rdata     = rd;
        tgt = {rpc[31:2], 2'b00};
        if (m_req) begin
            if (ack) begin
                if (rv)           m_addr = tgt;
                else if (m_stale) m_addr = m_stale_to;
                else begin
                    m_inst    = rd;
                    m_inst_pc = m_addr;
                    m_req     = 1'b0;
                    m_valid   = 1'b1;
                end
                m_stale = 1'b0;
            end else if (rv) begin
                m_stale    = 1'b1;
                m_stale_to = tgt;
            end
        end else if (m_valid) begin
            if (rv || rdy) begin
                m_addr  = rv ? tgt : m_addr + 32'd4;
                m_valid = 1'b0;
                m_req   = 1'b1;
            end
        end else begin
            if (rv) m_addr = tgt;
            m_req = 1'b1;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int n;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        inst_ready     = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Leave IDLE: one quiet cycle before the first request
        step("idle", 0, 0, 0, 0, 0);
        check("first_req", 32'(imem_req), 32'd1);

        // Zero-wait memory, decode always ready
        for (int i = 0; i < 8; i++) step("zw", 0, 0, 1, 1, pat());
        check("zw_next_addr", imem_addr, 32'd16);

        // Ack delayed by 3 cycles
        for (int i = 0; i < 3; i++) step("ackwait", 0, 0, 0, 1, 32'h0);
        step("ackwait.ack", 0, 0, 1, 1, pat());
        check("ackwait.valid", 32'(inst_valid), 32'd1);

        // Decode stalls for 5 cycles
        for (int i = 0; i < 5; i++) step("stall", 0, 0, 0, 0, 32'h0);
        step("stall.rel", 0, 0, 0, 1, 32'h0);
        check("stall.next", imem_addr, 32'd20);

        // Redirect to a misaligned target while offering an instruction
        step("out.fetch", 0, 0, 1, 0, pat());
        step("out.redir", 1, 32'h0000_1003, 0, 0, 32'h0);
        check("out.redir.addr", imem_addr, 32'h0000_1000);
        check("out.redir.valid", 32'(inst_valid), 32'd0);

        // Redirect during outstanding request, ack two cycles later
        step("flush.redir", 1, 32'h200, 0, 1, 32'h0);
        step("flush.wait", 0, 0, 0, 1, 32'h0);
        step("flush.ack", 0, 0, 1, 1, 32'hDEAD_BEEF);
        check("flush.valid", 32'(inst_valid), 32'd0);
        check("flush.addr", imem_addr, 32'h200);
        step("flush.refetch", 0, 0, 1, 1, pat());
        step("flush.accept", 0, 0, 0, 1, 32'h0);

        // Redirect and ack in the same cycle
        step("same.redir", 1, 32'h200, 1, 1, 32'hDEAD_BEEF);
        check("same.valid", 32'(inst_valid), 32'd0);
        check("same.addr", imem_addr, 32'h200);
        step("same.refetch", 0, 0, 1, 1, pat());
        step("same.accept", 0, 0, 0, 1, 32'h0);

        // Sequential step from the top of the address space
        step("wrap.redir", 1, 32'hFFFF_FFFC, 1, 1, 32'h0);
        step("wrap.fetch", 0, 0, 1, 0, pat());
        step("wrap.step", 0, 0, 0, 1, 32'h0);
        check("wrap.addr", imem_addr, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(7) == 0), $urandom, $urandom_range(1),
                 $urandom_range(1), $urandom);
        end

        // Reach an outstanding request, then reset mid-cycle
        n = 0;
        while (!m_req && n < 10) begin
            step("toreq", 0, 0, 0, 1, 32'h0);
            n++;
        end
        check("toreq.bound", 32'(m_req), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midreset");
        imem_ack = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("late_ack.req", 32'(imem_req), 32'd0);
        step("post.idle", 0, 0, 1, 0, 32'h0);
        check("post.addr", imem_addr, 32'h0);
        step("post.fetch", 0, 0, 1, 1, pat());
        step("post.accept", 0, 0, 0, 1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
